// File: rtl/mem_ctrl_pkg.sv
// Shared constants and response type for the memory port controller.
// rsp_t carries an error flag only when MEMCTRL_RANGE_CHK_EN is defined.
package mem_ctrl_pkg;

  localparam int unsigned DefWidth    = 16;
  localparam int unsigned DefAddrBits = 16;

  typedef struct packed {
    logic [DefWidth-1:0] data;
`ifdef MEMCTRL_RANGE_CHK_EN
    logic                err;
`endif
  } rsp_t;

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous response FIFO with async active-low reset.
// Depth need not be a power of two; pointers wrap explicitly.
module rsp_fifo
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter type elem_t = rsp_t,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  elem_t           wdata,
  output elem_t           rdata,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  elem_t           mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/mem_port_ctrl.sv
// Valid/ready front end for a 1-cycle registered-read single-port RAM.
// Define MEMCTRL_RANGE_CHK_EN to add rsp_err and block accesses at or above MEM_WORDS.
module mem_port_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned ADDR_BITS = DefAddrBits,
  parameter int unsigned RSP_DEPTH = 2,
  parameter int unsigned MEM_WORDS = 2 ** ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_BITS-1:0] req_adr,
  input  logic [WIDTH-1:0]     req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
`ifdef MEMCTRL_RANGE_CHK_EN
  output logic                 rsp_err,
`endif
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_adr,
  output logic [WIDTH-1:0]     ram_wdata,
  input  logic [WIDTH-1:0]     ram_rdata,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  if (RSP_DEPTH < 2 || MEM_WORDS == 0 || WIDTH != DefWidth) begin : g_bad_cfg
    $error("mem_port_ctrl: unsupported parameter combination");
  end

  logic            acc, rd_acc, in_range;
  logic            inflight_q;
  logic            push_req, push, pop;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  rsp_t            cur_rsp, head_rsp, out_rsp;

  // Credit counts the read in flight as well as buffered ones.
  assign req_ready = (32'(inflight_q) + 32'(fifo_count)) < RSP_DEPTH;
  assign acc       = req_valid & req_ready;
  assign rd_acc    = acc & ~req_we;

  assign ram_en    = acc & in_range;
  assign ram_we    = ram_en & req_we;
  assign ram_adr   = req_adr;
  assign ram_wdata = req_wdata;

`ifdef MEMCTRL_RANGE_CHK_EN
  logic err_q;

  assign in_range = 32'(req_adr) < MEM_WORDS;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= rd_acc & ~in_range;
    end
  end

  always_comb begin
    cur_rsp.data = err_q ? '0 : ram_rdata;
    cur_rsp.err  = err_q;
  end

  assign rsp_err = out_rsp.err;
`else
  assign in_range     = 1'b1;
  assign cur_rsp.data = ram_rdata;
`endif

  // ram_rdata is meaningful only in the cycle after a read was accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_acc;
    end
  end

  always_comb begin
    push_req = 1'b0;
    out_rsp  = head_rsp;
    if (inflight_q) begin
      if (fifo_empty) begin
        out_rsp  = cur_rsp;
        push_req = ~rsp_ready;
      end else begin
        push_req = 1'b1;
      end
    end
  end

  assign push      = push_req & ~fifo_full;
  assign pop       = ~fifo_empty & rsp_ready;
  assign rsp_valid = inflight_q | ~fifo_empty;
  assign rsp_data  = out_rsp.data;
  assign busy      = inflight_q | (fifo_count != '0);

  rsp_fifo #(
    .Depth  (RSP_DEPTH),
    .elem_t (rsp_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (cur_rsp),
    .rdata   (head_rsp),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a behavioural 1-cycle registered-read RAM.
// Range-check steps compile only when MEMCTRL_RANGE_CHK_EN is defined.
module tb_mem_port_ctrl;

  logic        clk;
  logic        reset_n;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_adr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        ram_en, ram_we;
  logic [15:0] ram_adr, ram_wdata, ram_rdata;
  logic        busy;
`ifdef MEMCTRL_RANGE_CHK_EN
  logic        rsp_err;
`endif

  int total = 0;
  int bad   = 0;
  int issued, got;
  logic ovf_seen = 1'b0;
  logic [15:0] cyc = 16'h0;
  logic [15:0] mem [0:65535];

  mem_port_ctrl #(
    .WIDTH     (16),
    .ADDR_BITS (16),
    .RSP_DEPTH (2),
    .MEM_WORDS (256)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
`ifdef MEMCTRL_RANGE_CHK_EN
    .rsp_err   (rsp_err),
`endif
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_adr   (ram_adr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM read register reloads every clock; non-read cycles load junk.
  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_adr] <= ram_wdata;
    ram_rdata <= (ram_en && !ram_we) ? mem[ram_adr] : (16'hDEAD ^ cyc);
    cyc <= cyc + 16'h1;
  end

  always @(posedge clk) begin
    if (reset_n && dut.push_req && dut.fifo_full) ovf_seen <= 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    #1;
  endtask

  task automatic drive_rd(input logic [15:0] adr);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_adr   = adr;
    #1;
  endtask

  task automatic drive_wr(input logic [15:0] adr, input logic [15:0] dat);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_adr   = adr;
    req_wdata = dat;
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_adr   = 16'h0;
    req_wdata = 16'h0;
    rsp_ready = 1'b1;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_req_ready", req_ready, 1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Preload adr 0..7 with 0xA0..0xA7 through the controller.
    for (int i = 0; i < 8; i++) begin
      drive_wr(16'(i), 16'h00A0 + 16'(i));
      chk("pre_req_ready", req_ready, 1);
      chk("pre_ram_we", ram_we, 1);
      chk("pre_ram_wdata", ram_wdata, 16'h00A0 + 16'(i));
    end
    idle();
    chk("pre_no_rsp", rsp_valid, 0);
    chk("pre_busy", busy, 0);

    // Write then read-after-write to the same address.
    drive_wr(16'h0010, 16'h1234);
    chk("raw_wr_adr", ram_adr, 16'h0010);
    drive_rd(16'h0010);
    chk("raw_rd_en", ram_en, 1);
    chk("raw_rd_we", ram_we, 0);
    chk("raw_wr_no_rsp", rsp_valid, 0);
    idle();
    chk("raw_rsp_valid", rsp_valid, 1);
    chk("raw_rsp_data", rsp_data, 16'h1234);
    idle();
    chk("raw_done", rsp_valid, 0);
    chk("raw_busy", busy, 0);

    // Back-to-back reads at full rate.
    for (int k = 0; k < 4; k++) begin
      drive_rd(16'(k));
      chk("b2b_req_ready", req_ready, 1);
      if (k > 0) begin
        chk("b2b_valid", rsp_valid, 1);
        chk("b2b_data", rsp_data, 16'h00A0 + 16'(k - 1));
      end
    end
    idle();
    chk("b2b_last_valid", rsp_valid, 1);
    chk("b2b_last_data", rsp_data, 16'h00A3);
    idle();
    chk("b2b_busy", busy, 0);

    // Backpressure fills the credit; third read must wait.
    rsp_ready = 1'b0;
    drive_rd(16'h0000);
    chk("bp_rd0_ready", req_ready, 1);
    drive_rd(16'h0001);
    chk("bp_rd1_ready", req_ready, 1);
    chk("bp_ft_data", rsp_data, 16'h00A0);
    drive_rd(16'h0002);
    chk("bp_rd2_stall", req_ready, 0);
    chk("bp_rd2_ram_en", ram_en, 0);
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      #1;
      chk("bp_hold_ready", req_ready, 0);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_data", rsp_data, 16'h00A0);
      chk("bp_hold_ram_en", ram_en, 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("bp_rel_data0", rsp_data, 16'h00A0);
    chk("bp_rel_ready0", req_ready, 0);
    @(negedge clk);
    #1;
    chk("bp_rel_data1", rsp_data, 16'h00A1);
    chk("bp_rel_ready1", req_ready, 1);
    chk("bp_rel_ram_en", ram_en, 1);
    idle();
    chk("bp_rel_valid2", rsp_valid, 1);
    chk("bp_rel_data2", rsp_data, 16'h00A2);
    idle();
    chk("bp_busy", busy, 0);

    // 8-read burst with rsp_ready alternating.
    issued = 0;
    got    = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      req_valid = (issued < 8);
      req_we    = 1'b0;
      req_adr   = 16'(issued);
      rsp_ready = (c % 2 == 0);
      #1;
      if (rsp_valid && rsp_ready) begin
        chk("burst_data", rsp_data, 16'h00A0 + 16'(got));
        got++;
      end
      if (req_valid && req_ready) issued++;
    end
    rsp_ready = 1'b1;
    idle();
    chk("burst_count", got, 8);
    chk("burst_issued", issued, 8);
    chk("burst_busy", busy, 0);

    // Reset with one read in flight and one buffered.
    rsp_ready = 1'b0;
    drive_rd(16'h0000);
    drive_rd(16'h0002);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("rstmid_busy_pre", busy, 1);
    chk("rstmid_head", rsp_data, 16'h00A0);
    reset_n = 1'b0;
    #1;
    chk("rstmid_valid", rsp_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ready", req_ready, 1);
    @(negedge clk);
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    drive_rd(16'h0001);
    chk("rstmid_no_stale", rsp_valid, 0);
    idle();
    chk("rstmid_valid_a1", rsp_valid, 1);
    chk("rstmid_data_a1", rsp_data, 16'h00A1);
    idle();
    chk("rstmid_only_one", rsp_valid, 0);

`ifdef MEMCTRL_RANGE_CHK_EN
    drive_rd(16'h0100);
    chk("oor_rd_ram_en", ram_en, 0);
    chk("oor_rd_ready", req_ready, 1);
    idle();
    chk("oor_rd_valid", rsp_valid, 1);
    chk("oor_rd_data", rsp_data, 0);
    chk("oor_rd_err", rsp_err, 1);
    drive_wr(16'h0100, 16'h5555);
    chk("oor_wr_ram_en", ram_en, 0);
    chk("oor_wr_no_rsp", rsp_valid, 0);
    drive_rd(16'h0000);
    idle();
    chk("ir_rd_data", rsp_data, 16'h00A0);
    chk("ir_rd_err", rsp_err, 0);
    idle();
`endif

    chk("no_push_while_full", ovf_seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
